// File: rtl/vanilla_scoreboard_tracker_multi_pkg.sv
// Shared types for the multi-rf, multi-class writeback scoreboard tracker.
// Class/rf encodings and the pre-decoded event bundle.
package vanilla_scoreboard_tracker_multi_pkg;

  localparam int sb_fld_w = 8;

  typedef enum logic [2:0] {
    e_sb_idiv        = 3'd0,
    e_sb_fdiv_fsqrt  = 3'd1,
    e_sb_dram_load   = 3'd2,
    e_sb_global_load = 3'd3,
    e_sb_group_load  = 3'd4,
    e_sb_dram_amo    = 3'd5,
    e_sb_group_amo   = 3'd6
  } sb_class_e;

  typedef enum logic {
    e_rf_int   = 1'b0,
    e_rf_float = 1'b1
  } sb_rf_e;

  typedef struct packed {
    logic                v;
    logic [sb_fld_w-1:0] rf;
    logic [sb_fld_w-1:0] cls;
    logic [sb_fld_w-1:0] id;
  } sb_evt_t;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vanilla_scoreboard_tracker_multi_if.sv
// Event inputs and status outputs of the scoreboard tracker.
// master drives events, slave is the tracker.
interface vanilla_scoreboard_tracker_multi_if #(
  parameter int num_rf_p      = 2,
  parameter int reg_els_p     = 32,
  parameter int num_class_p   = 8,
  parameter int count_width_p = 3
);
  import vanilla_scoreboard_tracker_multi_pkg::*;

  localparam int rf_w = safe_clog2(num_rf_p);
  localparam int aw   = safe_clog2(reg_els_p);
  localparam int cl_w = safe_clog2(num_class_p);
  localparam int pw   = aw + count_width_p + cl_w + 1;

  logic                          set_v_i;
  logic [rf_w-1:0]               set_rf_i;
  logic [cl_w-1:0]               set_class_i;
  logic [aw-1:0]                 set_id_i;
  logic [num_rf_p-1:0]           clear_v_i;
  logic [num_rf_p*cl_w-1:0]      clear_class_i;
  logic [num_rf_p*aw-1:0]        clear_id_i;

  logic [num_rf_p*reg_els_p*num_class_p-1:0] busy_o;
  logic [num_rf_p*reg_els_p-1:0] reg_busy_o;
  logic [num_rf_p*pw-1:0]        pending_total_o;
  logic                          timeout_o;
  logic [rf_w-1:0]               timeout_rf_o;
  logic [aw-1:0]                 timeout_id_o;
  logic                          overflow_o;
  logic                          underflow_o;

  modport master (
    output set_v_i, set_rf_i, set_class_i, set_id_i,
    output clear_v_i, clear_class_i, clear_id_i,
    input  busy_o, reg_busy_o, pending_total_o,
    input  timeout_o, timeout_rf_o, timeout_id_o,
    input  overflow_o, underflow_o
  );

  modport slave (
    input  set_v_i, set_rf_i, set_class_i, set_id_i,
    input  clear_v_i, clear_class_i, clear_id_i,
    output busy_o, reg_busy_o, pending_total_o,
    output timeout_o, timeout_rf_o, timeout_id_o,
    output overflow_o, underflow_o
  );

endinterface

// File: rtl/vanilla_sb_entry.sv
// One (rf, reg) slice: per-class saturating counters plus age counter.
// Emits single-cycle inc/dec/error/timeout pulses for the top to merge.
module vanilla_sb_entry
  import vanilla_scoreboard_tracker_multi_pkg::*;
#(
  parameter int num_class_p   = 8,
  parameter int count_width_p = 3,
  parameter int age_width_p   = 16,
  parameter int timeout_p     = 1000
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   set_v_i,
  input  logic [sb_fld_w-1:0]    set_class_i,
  input  logic                   clr_v_i,
  input  logic [sb_fld_w-1:0]    clr_class_i,
  output logic [num_class_p-1:0] busy_o,
  output logic                   reg_busy_o,
  output logic                   inc_o,
  output logic                   dec_o,
  output logic                   ovf_o,
  output logic                   unf_o,
  output logic                   to_o
);

  logic [count_width_p-1:0] cnt_q [num_class_p];
  logic [count_width_p-1:0] cnt_d [num_class_p];
  logic [age_width_p-1:0]   age_q, age_d;
  logic [num_class_p-1:0]   set_c, clr_c;
  logic                     any_d;

  always_comb begin
    for (int c = 0; c < num_class_p; c++) begin
      set_c[c]  = set_v_i && (set_class_i == sb_fld_w'(c));
      clr_c[c]  = clr_v_i && (clr_class_i == sb_fld_w'(c));
      busy_o[c] = (cnt_q[c] != '0);
    end
    reg_busy_o = |busy_o;
  end

  // a matched set+clear on one class nets to zero with no error
  always_comb begin
    inc_o = 1'b0;
    dec_o = 1'b0;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    any_d = 1'b0;
    for (int c = 0; c < num_class_p; c++) begin
      cnt_d[c] = cnt_q[c];
      if (set_c[c] && !clr_c[c]) begin
        if (cnt_q[c] == '1) begin
          ovf_o = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
          inc_o    = 1'b1;
        end
      end else if (clr_c[c] && !set_c[c]) begin
        if (cnt_q[c] == '0) begin
          unf_o = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] - 1'b1;
          dec_o    = 1'b1;
        end
      end
      any_d = any_d | (cnt_d[c] != '0);
    end
    age_d = '0;
    if (any_d && reg_busy_o) begin
      age_d = (age_q == '1) ? age_q : age_q + 1'b1;
    end
    to_o = any_d && (age_d == age_width_p'(timeout_p));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_class_p; c++) cnt_q[c] <= '0;
      age_q <= '0;
    end else begin
      for (int c = 0; c < num_class_p; c++) cnt_q[c] <= cnt_d[c];
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/vanilla_scoreboard_tracker_multi.sv
// Testbench-side scoreboard tracker for long-latency writebacks.
// Per-(rf,reg) slices plus pending totals, sticky errors and watchdog.
module vanilla_scoreboard_tracker_multi
  import vanilla_scoreboard_tracker_multi_pkg::*;
#(
  parameter int num_rf_p      = 2,
  parameter int reg_els_p     = 32,
  parameter int num_class_p   = 8,
  parameter int count_width_p = 3,
  parameter int age_width_p   = 16,
  parameter int timeout_p     = 1000
) (
  input logic clk_i,
  input logic reset_n_i,
  vanilla_scoreboard_tracker_multi_if.slave sb
);

  localparam int aw   = safe_clog2(reg_els_p);
  localparam int rf_w = safe_clog2(num_rf_p);
  localparam int cl_w = safe_clog2(num_class_p);
  localparam int pw   = aw + count_width_p + cl_w + 1;

  sb_evt_t set_evt;
  sb_evt_t clr_evt [num_rf_p];

  always_comb begin
    set_evt.v   = sb.set_v_i;
    set_evt.rf  = sb_fld_w'(sb.set_rf_i);
    set_evt.cls = sb_fld_w'(sb.set_class_i);
    set_evt.id  = sb_fld_w'(sb.set_id_i);
    for (int r = 0; r < num_rf_p; r++) begin
      clr_evt[r].v   = sb.clear_v_i[r];
      clr_evt[r].rf  = sb_fld_w'(r);
      clr_evt[r].cls = sb_fld_w'(sb.clear_class_i[r*cl_w +: cl_w]);
      clr_evt[r].id  = sb_fld_w'(sb.clear_id_i[r*aw +: aw]);
    end
  end

  logic [num_rf_p-1:0][reg_els_p-1:0] inc, dec, ovf, unf, to_hit;
  logic [num_rf_p-1:0][reg_els_p-1:0] rbusy;
  logic [pw-1:0] pend_q [num_rf_p];

  for (genvar r = 0; r < num_rf_p; r++) begin : g_rf
    for (genvar i = 0; i < reg_els_p; i++) begin : g_reg
      logic                   set_hit, clr_hit;
      logic [num_class_p-1:0] busy;

      // x0 of the integer file never holds a pending write
      assign set_hit = set_evt.v
                    && (set_evt.rf == sb_fld_w'(r))
                    && (set_evt.id == sb_fld_w'(i))
                    && !(r == 0 && i == 0);
      assign clr_hit = clr_evt[r].v
                    && (clr_evt[r].rf == sb_fld_w'(r))
                    && (clr_evt[r].id == sb_fld_w'(i));

      vanilla_sb_entry #(
        .num_class_p  (num_class_p),
        .count_width_p(count_width_p),
        .age_width_p  (age_width_p),
        .timeout_p    (timeout_p)
      ) u_entry (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .set_v_i    (set_hit),
        .set_class_i(set_evt.cls),
        .clr_v_i    (clr_hit),
        .clr_class_i(clr_evt[r].cls),
        .busy_o     (busy),
        .reg_busy_o (rbusy[r][i]),
        .inc_o      (inc[r][i]),
        .dec_o      (dec[r][i]),
        .ovf_o      (ovf[r][i]),
        .unf_o      (unf[r][i]),
        .to_o       (to_hit[r][i])
      );

      assign sb.busy_o[(r*reg_els_p+i)*num_class_p +: num_class_p] = busy;
      assign sb.reg_busy_o[r*reg_els_p+i] = rbusy[r][i];
    end
    assign sb.pending_total_o[r*pw +: pw] = pend_q[r];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < num_rf_p; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < num_rf_p; r++) begin
        pend_q[r] <= pend_q[r] + pw'(|inc[r]) - pw'(|dec[r]);
      end
    end
  end

  logic            hit;
  logic [rf_w-1:0] hit_rf;
  logic [aw-1:0]   hit_id;

  // lowest rf, then lowest id, wins a same-cycle tie
  always_comb begin
    hit    = 1'b0;
    hit_rf = '0;
    hit_id = '0;
    for (int r = 0; r < num_rf_p; r++) begin
      for (int i = 0; i < reg_els_p; i++) begin
        if (to_hit[r][i] && !hit) begin
          hit    = 1'b1;
          hit_rf = rf_w'(r);
          hit_id = aw'(i);
        end
      end
    end
  end

  logic            to_q, ovf_q, unf_q;
  logic [rf_w-1:0] to_rf_q;
  logic [aw-1:0]   to_id_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      to_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      to_rf_q <= '0;
      to_id_q <= '0;
    end else begin
      ovf_q <= ovf_q | (|ovf);
      unf_q <= unf_q | (|unf);
      if (!to_q && hit) begin
        to_q    <= 1'b1;
        to_rf_q <= hit_rf;
        to_id_q <= hit_id;
      end
    end
  end

  assign sb.timeout_o    = to_q;
  assign sb.timeout_rf_o = to_rf_q;
  assign sb.timeout_id_o = to_id_q;
  assign sb.overflow_o   = ovf_q;
  assign sb.underflow_o  = unf_q;

endmodule
